e_mdu: RTL and testbench
========================

// Module: e_mdu
// PURPOSE
//   Multiply/divide unit of the E stage. It consumes the two register operands
//   read out of the D-stage register file (after D/E forwarding) and owns the
//   HI/LO registers.
//   Mult/div run for a fixed number of cycles with a busy flag. mthi/mtlo
//   write HI/LO in one cycle. mfhi/mflo read HI/LO combinationally into the
//   E-stage result mux.
//   The hazard unit stalls any MDU instruction in D while (start | busy).
// PARAMETERS
//   MULT_CYCLES  5   busy cycles for mult/multu (>=1)
//   DIV_CYCLES   10  busy cycles for div/divu (>=1)
// PORTS
//   clk     in   1   clock
//   reset   in   1   synchronous, active-high
//   start   in   1   E-stage instr is an MDU op this cycle (single-cycle qualifier)
//   mdu_op  in   4   0 none,1 mult,2 multu,3 div,4 divu,5 mthi,6 mtlo,7 mfhi,8 mflo
//   req     in   1   exception/interrupt flush this cycle; cancels any start
//   A       in   32  rs operand (forwarded)
//   B       in   32  rt operand (forwarded)
//   busy    out  1   mult/div in progress
//   hi      out  32  HI register
//   lo      out  32  LO register
//   rd      out  32  mfhi->hi, mflo->lo, otherwise 0 (combinational)
// BEHAVIOUR
//   Reset
//   - hi=0, lo=0, busy=0, cycle counter=0.
//   - Any pending result is discarded. Reset overrides all other inputs.
//   Accepted operation
//   - An op is accepted at a clk edge only when start=1, req=0 and busy=0.
//   - start while busy=1 is ignored; the stall logic guarantees it never occurs.
//   mult / multu / div / divu accepted in cycle T
//   - A and B are latched at the end of T.
//   - busy=1 for cycles T+1 .. T+N, where N = MULT_CYCLES or DIV_CYCLES.
//   - The result is computed into shadow registers. hi/lo are updated at the
//     edge that ends cycle T+N.
//   - busy=0 and the new hi/lo are visible in cycle T+N+1.
//   - hi/lo keep their old values throughout T+1 .. T+N.
//   Arithmetic rules
//   - mult:  {hi,lo} = $signed(A) * $signed(B), 64-bit.
//   - multu: {hi,lo} = A * B, unsigned 64-bit.
//   - div:   lo = quotient truncated toward zero; hi = remainder, which takes
//     the sign of the dividend.
//   - div special case: 0x80000000 / -1 gives lo=0x80000000, hi=0.
//   - divu: lo = A / B, hi = A % B, unsigned.
//   - B==0 on div or divu: busy sequence still runs for DIV_CYCLES; hi/lo are
//     left unchanged.
//   mthi / mtlo accepted in cycle T
//   - hi (or lo) <= A at the end of T. busy stays 0.
//   mfhi / mflo
//   - rd reflects the current hi/lo in the same cycle. No state change.
//   - The counter reaching N in a cycle where a new start arrives is
//     impossible (busy=1 at that point), so no priority rule is needed.
//   req
//   - req affects only acceptance. An operation already busy runs to
//     completion and updates hi/lo; the flushed instruction is never the busy one.
//   Counter
//   - Loads N on acceptance, decrements while busy, and busy drops when it
//     reaches 0.
// TESTING
//   1. reset 1 cycle -> hi=lo=0, busy=0, rd=0 on mdu_op=7 and 8.
//   2. mult: start=1, op=1, A=0xFFFFFFFE (-2), B=3
//      -> busy=1 for exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
//      Same operands with multu -> hi=0x00000002, lo=0xFFFFFFFA.
//   3. div: op=3, A=-7 (0xFFFFFFF9), B=2
//      -> after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//      divu: A=7, B=2 -> lo=3, hi=1.
//   4. preload: mthi A=0x1234, mtlo A=0x5678 -> one cycle later hi=0x1234, lo=0x5678.
//      Then div with B=0 -> busy for 10 cycles, hi/lo unchanged.
//      mfhi -> rd=0x1234.
//   5. start=1, req=1, op=1 or op=5 -> busy stays 0, hi/lo unchanged.
//      Start during busy with req=0 -> ignored, first result intact.
//   6. reset asserted at busy cycle 3 of a mult -> next cycle busy=0, hi=lo=0,
//      and the result never appears.

Source files
------------

// File: rtl/e_mdu.sv
// rtl/e_mdu.sv - E-stage multiply/divide unit owning the HI/LO registers
//
// Ports:
//   clk     clock
//   reset   synchronous, active-high; clears hi/lo/busy and drops any pending result
//   start   E-stage instruction is an MDU op this cycle
//   mdu_op  0 none,1 mult,2 multu,3 div,4 divu,5 mthi,6 mtlo,7 mfhi,8 mflo
//   req     exception/interrupt flush; blocks acceptance this cycle
//   A, B    forwarded rs/rt operands
//   busy    mult/div in progress
//   hi, lo  HI/LO registers
//   rd      mfhi/mflo read data (combinational), 0 otherwise
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mdu_op,
  input  logic        req,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rd
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  logic [CW-1:0] cnt;
  logic [3:0]    op_q;
  logic [31:0]   a_q;
  logic [31:0]   b_q;
  logic          accept;

  assign accept = start & ~req & ~busy;

  // Result datapath works on the operands latched at acceptance.
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        div_ovf;
  logic [31:0] dsafe;
  logic [31:0] quot_s, rem_s, quot_u, rem_u;
  logic        res_we;
  logic [31:0] res_hi, res_lo;

  assign prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
  assign prod_u = {32'd0, a_q} * {32'd0, b_q};

  // Dividing by 1 in the overflow case yields exactly lo=0x80000000, hi=0,
  // and avoids the undefined INT_MIN / -1. A zero divisor is also replaced so
  // the dividers never see 0; that result is discarded anyway.
  assign div_ovf = (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
  assign dsafe   = ((b_q == 32'd0) || div_ovf) ? 32'd1 : b_q;
  assign quot_s  = $signed(a_q) / $signed(dsafe);
  assign rem_s   = $signed(a_q) % $signed(dsafe);
  assign quot_u  = a_q / dsafe;
  assign rem_u   = a_q % dsafe;

  always_comb begin
    res_we = 1'b0;
    res_hi = hi;
    res_lo = lo;
    case (op_q)
      OP_MULT:  begin res_we = 1'b1; res_hi = prod_s[63:32]; res_lo = prod_s[31:0]; end
      OP_MULTU: begin res_we = 1'b1; res_hi = prod_u[63:32]; res_lo = prod_u[31:0]; end
      OP_DIV:   begin res_we = (b_q != 32'd0); res_hi = rem_s; res_lo = quot_s; end
      OP_DIVU:  begin res_we = (b_q != 32'd0); res_hi = rem_u; res_lo = quot_u; end
      default:  res_we = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi   <= 32'd0;
      lo   <= 32'd0;
      cnt  <= '0;
      busy <= 1'b0;
      op_q <= 4'd0;
      a_q  <= 32'd0;
      b_q  <= 32'd0;
    end else if (accept) begin
      case (mdu_op)
        OP_MULT, OP_MULTU: begin
          op_q <= mdu_op;
          a_q  <= A;
          b_q  <= B;
          cnt  <= CW'(MULT_CYCLES);
          busy <= 1'b1;
        end
        OP_DIV, OP_DIVU: begin
          op_q <= mdu_op;
          a_q  <= A;
          b_q  <= B;
          cnt  <= CW'(DIV_CYCLES);
          busy <= 1'b1;
        end
        OP_MTHI: hi <= A;
        OP_MTLO: lo <= A;
        default: ;
      endcase
    end else if (busy) begin
      cnt <= cnt - 1'b1;
      // Last busy cycle: commit the result on this edge.
      if (cnt == CW'(1)) begin
        busy <= 1'b0;
        if (res_we) begin
          hi <= res_hi;
          lo <= res_lo;
        end
      end
    end
  end

  always_comb begin
    rd = 32'd0;
    if (mdu_op == OP_MFHI)      rd = hi;
    else if (mdu_op == OP_MFLO) rd = lo;
  end

endmodule

// File: tb/tb_e_mdu.sv
// tb/tb_e_mdu.sv - directed self-checking bench for e_mdu
module tb_e_mdu;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  mdu_op;
  logic        req;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rd;

  int n_checks = 0;
  int n_fail   = 0;

  e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .mdu_op(mdu_op), .req(req),
    .A(A), .B(B), .busy(busy), .hi(hi), .lo(lo), .rd(rd)
  );

  always #5 clk = ~clk;

  // Present one op for a single cycle; returns at the negedge of cycle T+1.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; mdu_op = op; A = a; B = b;
    @(negedge clk);
    start = 1'b0; mdu_op = 4'd0;
  endtask

  // Issue op and count busy cycles (bounded); held=0 if hi/lo moved while busy.
  task automatic run_busy(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int cycles, output bit held);
    logic [31:0] hi0, lo0;
    hi0 = hi; lo0 = lo;
    issue(op, a, b);
    cycles = 0; held = 1'b1;
    while (busy === 1'b1 && cycles < 40) begin
      cycles++;
      if (hi !== hi0 || lo !== lo0) held = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; mdu_op = 4'd0; req = 1'b0; A = 32'd0; B = 32'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL reset_hi got=%h exp=0", hi); end
    n_checks++; if (lo !== 32'd0) begin n_fail++; $display("FAIL reset_lo got=%h exp=0", lo); end
    mdu_op = 4'd7; #1;
    n_checks++; if (rd !== 32'd0) begin n_fail++; $display("FAIL reset_mfhi got=%h exp=0", rd); end
    mdu_op = 4'd8; #1;
    n_checks++; if (rd !== 32'd0) begin n_fail++; $display("FAIL reset_mflo got=%h exp=0", rd); end
    mdu_op = 4'd0;
  endtask

  task automatic test_mult;
    int cyc; bit held;
    run_busy(4'd1, 32'hFFFF_FFFE, 32'd3, cyc, held);
    n_checks++; if (cyc != 5) begin n_fail++; $display("FAIL mult_busy_cycles got=%0d exp=5", cyc); end
    n_checks++; if (!held) begin n_fail++; $display("FAIL mult_hold got=changed exp=held"); end
    n_checks++; if (hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mult_hi got=%h exp=ffffffff", hi); end
    n_checks++; if (lo !== 32'hFFFF_FFFA) begin n_fail++; $display("FAIL mult_lo got=%h exp=fffffffa", lo); end
    run_busy(4'd2, 32'hFFFF_FFFE, 32'd3, cyc, held);
    n_checks++; if (cyc != 5) begin n_fail++; $display("FAIL multu_busy_cycles got=%0d exp=5", cyc); end
    n_checks++; if (hi !== 32'h0000_0002) begin n_fail++; $display("FAIL multu_hi got=%h exp=00000002", hi); end
    n_checks++; if (lo !== 32'hFFFF_FFFA) begin n_fail++; $display("FAIL multu_lo got=%h exp=fffffffa", lo); end
  endtask

  task automatic test_div;
    int cyc; bit held;
    run_busy(4'd3, 32'hFFFF_FFF9, 32'd2, cyc, held);
    n_checks++; if (cyc != 10) begin n_fail++; $display("FAIL div_busy_cycles got=%0d exp=10", cyc); end
    n_checks++; if (!held) begin n_fail++; $display("FAIL div_hold got=changed exp=held"); end
    n_checks++; if (lo !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_lo got=%h exp=fffffffd", lo); end
    n_checks++; if (hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_hi got=%h exp=ffffffff", hi); end
    run_busy(4'd4, 32'd7, 32'd2, cyc, held);
    n_checks++; if (cyc != 10) begin n_fail++; $display("FAIL divu_busy_cycles got=%0d exp=10", cyc); end
    n_checks++; if (lo !== 32'd3) begin n_fail++; $display("FAIL divu_lo got=%h exp=3", lo); end
    n_checks++; if (hi !== 32'd1) begin n_fail++; $display("FAIL divu_hi got=%h exp=1", hi); end
    run_busy(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, cyc, held);
    n_checks++; if (lo !== 32'h8000_0000) begin n_fail++; $display("FAIL div_ovf_lo got=%h exp=80000000", lo); end
    n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL div_ovf_hi got=%h exp=0", hi); end
  endtask

  task automatic test_move_divzero;
    int cyc; bit held;
    issue(4'd5, 32'h0000_1234, 32'd0);
    n_checks++; if (hi !== 32'h1234) begin n_fail++; $display("FAIL mthi got=%h exp=1234", hi); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mthi_busy got=%0b exp=0", busy); end
    issue(4'd6, 32'h0000_5678, 32'd0);
    n_checks++; if (lo !== 32'h5678) begin n_fail++; $display("FAIL mtlo got=%h exp=5678", lo); end
    run_busy(4'd3, 32'd99, 32'd0, cyc, held);
    n_checks++; if (cyc != 10) begin n_fail++; $display("FAIL divzero_busy_cycles got=%0d exp=10", cyc); end
    n_checks++; if (hi !== 32'h1234 || lo !== 32'h5678) begin n_fail++; $display("FAIL divzero_hilo got=%h/%h exp=1234/5678", hi, lo); end
    run_busy(4'd4, 32'd99, 32'd0, cyc, held);
    n_checks++; if (hi !== 32'h1234 || lo !== 32'h5678) begin n_fail++; $display("FAIL divuzero_hilo got=%h/%h exp=1234/5678", hi, lo); end
    mdu_op = 4'd7; #1;
    n_checks++; if (rd !== 32'h1234) begin n_fail++; $display("FAIL mfhi got=%h exp=1234", rd); end
    mdu_op = 4'd8; #1;
    n_checks++; if (rd !== 32'h5678) begin n_fail++; $display("FAIL mflo got=%h exp=5678", rd); end
    mdu_op = 4'd1; #1;
    n_checks++; if (rd !== 32'd0) begin n_fail++; $display("FAIL rd_other got=%h exp=0", rd); end
    mdu_op = 4'd0;
  endtask

  task automatic test_req;
    @(negedge clk);
    start = 1'b1; req = 1'b1; mdu_op = 4'd1; A = 32'hFFFF_FFFE; B = 32'd3;
    @(negedge clk);
    start = 1'b0; req = 1'b0; mdu_op = 4'd0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL req_mult_busy got=%0b exp=0", busy); end
    repeat (6) @(negedge clk);
    n_checks++; if (hi !== 32'h1234 || lo !== 32'h5678) begin n_fail++; $display("FAIL req_mult_hilo got=%h/%h exp=1234/5678", hi, lo); end
    start = 1'b1; req = 1'b1; mdu_op = 4'd5; A = 32'h0000_DEAD;
    @(negedge clk);
    start = 1'b0; req = 1'b0; mdu_op = 4'd0;
    n_checks++; if (hi !== 32'h1234) begin n_fail++; $display("FAIL req_mthi got=%h exp=1234", hi); end
  endtask

  task automatic test_back_to_back;
    int cyc;
    issue(4'd1, 32'hFFFF_FFFE, 32'd3);
    // Busy cycle 1: an mtlo and a fresh start must both be ignored.
    start = 1'b1; mdu_op = 4'd6; A = 32'h55; B = 32'd7;
    cyc = 1;
    @(negedge clk);
    start = 1'b0; mdu_op = 4'd0;
    while (busy === 1'b1 && cyc < 40) begin
      cyc++;
      @(negedge clk);
    end
    n_checks++; if (cyc != 5) begin n_fail++; $display("FAIL busy_start_cycles got=%0d exp=5", cyc); end
    n_checks++; if (hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL busy_start_hi got=%h exp=ffffffff", hi); end
    n_checks++; if (lo !== 32'hFFFF_FFFA) begin n_fail++; $display("FAIL busy_start_lo got=%h exp=fffffffa", lo); end
  endtask

  task automatic test_reset_abort;
    issue(4'd2, 32'hFFFF_FFFE, 32'd3);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got=%0b exp=0", busy); end
    n_checks++; if (hi !== 32'd0 || lo !== 32'd0) begin n_fail++; $display("FAIL abort_hilo got=%h/%h exp=0/0", hi, lo); end
    reset = 1'b0;
    repeat (8) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy_late got=%0b exp=0", busy); end
    n_checks++; if (hi !== 32'd0 || lo !== 32'd0) begin n_fail++; $display("FAIL abort_hilo_late got=%h/%h exp=0/0", hi, lo); end
  endtask

  initial begin
    test_reset;
    test_mult;
    test_div;
    test_move_divzero;
    test_req;
    test_back_to_back;
    test_reset_abort;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
